// File: rtl/pcs_tx_gearbox_ml_if.sv
// Encoder/PMA-facing bus of the multi-lane 66b TX gearbox.
// The slave side is the gearbox; the master side is the encoder/bench.
interface pcs_tx_gearbox_ml_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_N = 1
);
  logic [LANE_N*2-1:0]      head_i;
  logic [LANE_N*DATA_W-1:0] data_i;
  logic                     ready_o;
  logic [5:0]               seq_o;
  logic [1:0]               part_o;
  logic [LANE_N*DATA_W-1:0] data_o;

  modport master (output head_i, data_i, input ready_o, seq_o, part_o, data_o);
  modport slave  (input head_i, data_i, output ready_o, seq_o, part_o, data_o);
endinterface

// File: rtl/pcs_tx_gearbox_ml.sv
// Multi-lane 66b -> DATA_W transmit gearbox with a shared 33-cycle sequence
// counter; each period ends block-aligned via one stall cycle.
module pcs_tx_gearbox_ml #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANE_N = 1
) (
  input  logic               clk,
  input  logic               nreset,
  pcs_tx_gearbox_ml_if.slave gb
);
  localparam int unsigned HEAD_W = 2;
  localparam int unsigned CNT_N  = 64 / DATA_W;
  localparam int unsigned SEQ_N  = 66 / HEAD_W;
  localparam int unsigned CAT_W  = 2 * DATA_W;

  if (DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("pcs_tx_gearbox_ml: DATA_W must be 16, 32 or 64");
  end
  if (LANE_N < 1 || LANE_N > 8) begin : g_bad_lane_n
    $error("pcs_tx_gearbox_ml: LANE_N must be in 1..8");
  end

  logic [5:0]               seq_q;
  logic [5:0]               part_c;
  logic [5:0]               blk_c;
  logic [6:0]               fill_c;
  logic                     stall_c;
  logic [DATA_W-1:0]        buf_q [LANE_N];
  logic [DATA_W-1:0]        buf_d [LANE_N];
  logic [LANE_N*DATA_W-1:0] word_d;
  logic [LANE_N*DATA_W-1:0] data_q;
  logic [CAT_W-1:0]         chunk_c;
  logic [CAT_W-1:0]         cat_c;

  always_comb begin
    part_c  = 6'(seq_q % 6'(CNT_N));
    blk_c   = 6'(seq_q / 6'(CNT_N));
    stall_c = (seq_q == 6'(SEQ_N - 1));
    fill_c  = (part_c == '0) ? {blk_c, 1'b0} : {blk_c + 6'd1, 1'b0};
  end

  // Buffer bits above the fill level are kept at 0, so OR-ing the shifted
  // chunk onto the whole buffer is equivalent to concatenating at the fill.
  always_comb begin
    word_d  = '0;
    chunk_c = '0;
    cat_c   = '0;
    for (int unsigned l = 0; l < LANE_N; l++) begin
      buf_d[l] = '0;
      chunk_c  = '0;
      if (part_c == '0)
        chunk_c[DATA_W+HEAD_W-1:0] = {gb.data_i[l*DATA_W +: DATA_W],
                                      gb.head_i[l*HEAD_W +: HEAD_W]};
      else
        chunk_c[DATA_W-1:0] = gb.data_i[l*DATA_W +: DATA_W];
      cat_c = (chunk_c << fill_c) | CAT_W'(buf_q[l]);
      if (stall_c) begin
        word_d[l*DATA_W +: DATA_W] = buf_q[l];
      end else begin
        word_d[l*DATA_W +: DATA_W] = cat_c[DATA_W-1:0];
        buf_d[l]                   = cat_c[DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q  <= '0;
      data_q <= '0;
      for (int unsigned l = 0; l < LANE_N; l++) buf_q[l] <= '0;
    end else begin
      seq_q  <= stall_c ? '0 : seq_q + 6'd1;
      data_q <= word_d;
      for (int unsigned l = 0; l < LANE_N; l++) buf_q[l] <= buf_d[l];
    end
  end

  assign gb.ready_o = !nreset || !stall_c;
  assign gb.part_o  = (!nreset || stall_c) ? '0 : part_c[1:0];
  assign gb.seq_o   = seq_q;
  assign gb.data_o  = data_q;

endmodule

// File: tb/tb_pcs_tx_gearbox_ml.sv
// Self-checking bench for pcs_tx_gearbox_ml: three instances (32b x4 lanes,
// 64b, 16b) checked against a serial bit-stream model of the 66b blocks.
module tb_pcs_tx_gearbox_ml;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  pcs_tx_gearbox_ml_if #(.DATA_W(32), .LANE_N(4)) if32 ();
  pcs_tx_gearbox_ml_if #(.DATA_W(64), .LANE_N(1)) if64 ();
  pcs_tx_gearbox_ml_if #(.DATA_W(16), .LANE_N(1)) if16 ();

  pcs_tx_gearbox_ml #(.DATA_W(32), .LANE_N(4)) dut32 (.clk(clk), .nreset(nreset), .gb(if32.slave));
  pcs_tx_gearbox_ml #(.DATA_W(64), .LANE_N(1)) dut64 (.clk(clk), .nreset(nreset), .gb(if64.slave));
  pcs_tx_gearbox_ml #(.DATA_W(16), .LANE_N(1)) dut16 (.clk(clk), .nreset(nreset), .gb(if16.slave));

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned data_mode = 0;
  int unsigned cur_s = 0;
  logic [1:0]  head_cfg [6];
  logic [1:0]  blk_head [6];
  logic [63:0] blk_pay  [6];
  logic [63:0] exp_w    [6];
  bit          mq [6][$];

  // Model slots 0..3 are the 32b lanes, 4 the 64b lane, 5 the 16b lane.
  always @(posedge clk) cyc <= nreset ? cyc + 1 : 0;

  function automatic int unsigned lane_w(int unsigned m);
    return (m < 4) ? 32 : ((m == 4) ? 64 : 16);
  endfunction

  // Word i of a period when every block is head=01 with zero payload.
  function automatic logic [63:0] walk_word(int unsigned w, int unsigned i);
    logic [63:0] r;
    int unsigned off;
    r = '0;
    for (int unsigned b = 0; b < w / 2; b++) begin
      off = 66 * b;
      if (off >= i * w && off < (i + 1) * w) r[off - i * w] = 1'b1;
    end
    return r;
  endfunction

  task automatic drive_cycle();
    int unsigned s, w, p;
    logic [63:0] d;
    logic [1:0]  h;
    s = cyc % 33;
    cur_s = s;
    for (int unsigned m = 0; m < 6; m++) begin
      w = lane_w(m);
      p = s % (64 / w);
      h = 2'($urandom);
      d = {$urandom, $urandom};
      if (s != 32) begin
        if (p == 0) begin
          blk_head[m] = head_cfg[m];
          case (data_mode)
            0:       blk_pay[m] = '0;
            1:       blk_pay[m] = '1;
            default: blk_pay[m] = {$urandom, $urandom};
          endcase
          h = blk_head[m];
          for (int i = 0; i < 2; i++) mq[m].push_back(h[i]);
        end
        d = blk_pay[m] >> (p * w);
        for (int unsigned i = 0; i < w; i++) mq[m].push_back(d[i]);
      end
      exp_w[m] = '0;
      for (int unsigned i = 0; i < w; i++)
        if (mq[m].size() > 0) exp_w[m][i] = mq[m].pop_front();
      if (m < 4) begin
        if32.head_i[m*2 +: 2]   = h;
        if32.data_i[m*32 +: 32] = d[31:0];
      end else if (m == 4) begin
        if64.head_i = h;
        if64.data_i = d;
      end else begin
        if16.head_i = h;
        if16.data_i = d[15:0];
      end
    end
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    if32.head_i = 8'($urandom);
    if32.data_i = {$urandom, $urandom, $urandom, $urandom};
    if64.head_i = 2'($urandom);
    if64.data_i = {$urandom, $urandom};
    if16.head_i = 2'($urandom);
    if16.data_i = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic release_reset();
    nreset = 1'b1;
    for (int m = 0; m < 6; m++) mq[m].delete();
    drive_cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    n_checks++; if (if32.seq_o !== 6'd0) begin n_errors++; $display("FAIL reset_seq: got %0d, expected 0", if32.seq_o); end
    n_checks++; if (if32.ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, expected 1", if32.ready_o); end
    n_checks++; if (if32.part_o !== 2'd0) begin n_errors++; $display("FAIL reset_part: got %0d, expected 0", if32.part_o); end
    n_checks++; if (if32.data_o !== 128'd0) begin n_errors++; $display("FAIL reset_data32: got %h, expected 0", if32.data_o); end
    n_checks++; if (if64.data_o !== 64'd0) begin n_errors++; $display("FAIL reset_data64: got %h, expected 0", if64.data_o); end
    n_checks++; if (if16.data_o !== 16'd0) begin n_errors++; $display("FAIL reset_data16: got %h, expected 0", if16.data_o); end
  endtask

  task automatic test_header_walk();
    logic [63:0] ww;
    data_mode = 0;
    for (int m = 0; m < 6; m++) head_cfg[m] = 2'b01;
    @(negedge clk);
    apply_reset();
    release_reset();
    repeat (34) begin
      @(negedge clk);
      ww = walk_word(32, cur_s);
      n_checks++; if (if32.data_o[31:0] !== ww[31:0]) begin n_errors++; $display("FAIL walk32 s=%0d: got %h, expected %h", cur_s, if32.data_o[31:0], ww[31:0]); end
      n_checks++; if (if32.data_o[31:0] !== exp_w[0][31:0]) begin n_errors++; $display("FAIL walk32_model s=%0d: got %h, expected %h", cur_s, if32.data_o[31:0], exp_w[0][31:0]); end
      ww = walk_word(64, cur_s);
      n_checks++; if (if64.data_o !== ww) begin n_errors++; $display("FAIL walk64 s=%0d: got %h, expected %h", cur_s, if64.data_o, ww); end
      n_checks++; if (if64.data_o !== exp_w[4]) begin n_errors++; $display("FAIL walk64_model s=%0d: got %h, expected %h", cur_s, if64.data_o, exp_w[4]); end
      ww = walk_word(16, cur_s);
      n_checks++; if (if16.data_o !== ww[15:0]) begin n_errors++; $display("FAIL walk16 s=%0d: got %h, expected %h", cur_s, if16.data_o, ww[15:0]); end
      n_checks++; if (if16.data_o !== exp_w[5][15:0]) begin n_errors++; $display("FAIL walk16_model s=%0d: got %h, expected %h", cur_s, if16.data_o, exp_w[5][15:0]); end
      n_checks++; if (if64.ready_o !== ((cyc % 33) != 32)) begin n_errors++; $display("FAIL walk_ready cyc=%0d: got %b", cyc, if64.ready_o); end
      drive_cycle();
    end
  endtask

  task automatic test_all_ones();
    data_mode = 1;
    for (int m = 0; m < 6; m++) head_cfg[m] = 2'b10;
    @(negedge clk);
    apply_reset();
    release_reset();
    repeat (67) begin
      @(negedge clk);
      n_checks++; if (if32.data_o[31:0] !== exp_w[0][31:0]) begin n_errors++; $display("FAIL ones_model s=%0d: got %h, expected %h", cur_s, if32.data_o[31:0], exp_w[0][31:0]); end
      if (cur_s == 0) begin
        n_checks++; if (if32.data_o[31:0] !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL ones_word0: got %h, expected fffffffe", if32.data_o[31:0]); end
      end
      if (cur_s == 32) begin
        n_checks++; if (if32.data_o[31:0] !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL ones_stall: got %h, expected ffffffff", if32.data_o[31:0]); end
      end
      drive_cycle();
    end
  endtask

  task automatic test_sequence();
    int unsigned s_now;
    logic [1:0] ep;
    data_mode = 2;
    @(negedge clk);
    apply_reset();
    release_reset();
    repeat (98) begin
      @(negedge clk);
      s_now = cyc % 33;
      n_checks++; if (if32.ready_o !== (cyc != 32 && cyc != 65 && cyc != 98)) begin n_errors++; $display("FAIL seq_ready cyc=%0d: got %b", cyc, if32.ready_o); end
      n_checks++; if (if32.seq_o !== 6'(s_now)) begin n_errors++; $display("FAIL seq_value cyc=%0d: got %0d, expected %0d", cyc, if32.seq_o, s_now); end
      ep = (s_now == 32) ? 2'd0 : 2'(s_now % 2);
      n_checks++; if (if32.part_o !== ep) begin n_errors++; $display("FAIL part32 cyc=%0d: got %0d, expected %0d", cyc, if32.part_o, ep); end
      ep = (s_now == 32) ? 2'd0 : 2'(s_now % 4);
      n_checks++; if (if16.part_o !== ep) begin n_errors++; $display("FAIL part16 cyc=%0d: got %0d, expected %0d", cyc, if16.part_o, ep); end
      n_checks++; if (if64.part_o !== 2'd0) begin n_errors++; $display("FAIL part64 cyc=%0d: got %0d, expected 0", cyc, if64.part_o); end
      drive_cycle();
    end
  endtask

  task automatic test_multilane();
    data_mode = 2;
    head_cfg[0] = 2'b01; head_cfg[1] = 2'b10; head_cfg[2] = 2'b01; head_cfg[3] = 2'b10;
    head_cfg[4] = 2'b10; head_cfg[5] = 2'b01;
    @(negedge clk);
    apply_reset();
    release_reset();
    repeat (70) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        n_checks++; if (if32.data_o[l*32 +: 32] !== exp_w[l][31:0]) begin n_errors++; $display("FAIL lane%0d s=%0d: got %h, expected %h", l, cur_s, if32.data_o[l*32 +: 32], exp_w[l][31:0]); end
      end
      n_checks++; if (if64.data_o !== exp_w[4]) begin n_errors++; $display("FAIL rand64 s=%0d: got %h, expected %h", cur_s, if64.data_o, exp_w[4]); end
      n_checks++; if (if16.data_o !== exp_w[5][15:0]) begin n_errors++; $display("FAIL rand16 s=%0d: got %h, expected %h", cur_s, if16.data_o, exp_w[5][15:0]); end
      drive_cycle();
    end
  endtask

  task automatic test_mid_reset();
    data_mode = 2;
    for (int m = 0; m < 6; m++) head_cfg[m] = 2'($urandom);
    @(negedge clk);
    apply_reset();
    release_reset();
    repeat (16) begin
      @(negedge clk);
      n_checks++; if (if32.data_o[31:0] !== exp_w[0][31:0]) begin n_errors++; $display("FAIL pre_reset s=%0d: got %h, expected %h", cur_s, if32.data_o[31:0], exp_w[0][31:0]); end
      drive_cycle();
    end
    @(negedge clk);
    n_checks++; if (if32.seq_o !== 6'd17) begin n_errors++; $display("FAIL pre_reset_seq: got %0d, expected 17", if32.seq_o); end
    apply_reset();
    n_checks++; if (if32.seq_o !== 6'd0) begin n_errors++; $display("FAIL mid_reset_seq: got %0d, expected 0", if32.seq_o); end
    n_checks++; if (if32.data_o !== 128'd0) begin n_errors++; $display("FAIL mid_reset_data: got %h, expected 0", if32.data_o); end
    n_checks++; if (if16.data_o !== 16'd0) begin n_errors++; $display("FAIL mid_reset_data16: got %h, expected 0", if16.data_o); end
    for (int m = 0; m < 6; m++) head_cfg[m] = 2'($urandom);
    release_reset();
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      n_checks++; if (if32.data_o[l*32 +: 2] !== head_cfg[l]) begin n_errors++; $display("FAIL post_reset_head lane%0d: got %b, expected %b", l, if32.data_o[l*32 +: 2], head_cfg[l]); end
    end
    drive_cycle();
    repeat (35) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        n_checks++; if (if32.data_o[l*32 +: 32] !== exp_w[l][31:0]) begin n_errors++; $display("FAIL post_reset lane%0d s=%0d: got %h, expected %h", l, cur_s, if32.data_o[l*32 +: 32], exp_w[l][31:0]); end
      end
      n_checks++; if (if16.data_o !== exp_w[5][15:0]) begin n_errors++; $display("FAIL post_reset16 s=%0d: got %h, expected %h", cur_s, if16.data_o, exp_w[5][15:0]); end
      drive_cycle();
    end
  endtask

  initial begin
    if32.head_i = '0; if32.data_i = '0;
    if64.head_i = '0; if64.data_i = '0;
    if16.head_i = '0; if16.data_i = '0;
    test_reset();
    test_header_walk();
    test_all_ones();
    test_sequence();
    test_multilane();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
